// File: rtl/mcu_bus_if.sv
// MCU-side parallel bus between the pad ring and the register bridge.
interface mcu_bus_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) ();
  logic              mcu_mstr;
  logic              write_enable;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic              fpga_ack;
  logic              addr_err;

  modport slave (
    input  mcu_mstr, write_enable, address, data_in,
    output data_out, data_oe, fpga_ack, addr_err
  );

  modport master (
    output mcu_mstr, write_enable, address, data_in,
    input  data_out, data_oe, fpga_ack, addr_err
  );
endinterface

// File: rtl/mcu_bus_bridge.sv
// MCU-to-FPGA register bridge: synchronised request, SETUP/ACK/HOLD handshake,
// masked register writes, read mux with strobes and sticky range error.
module mcu_bus_bridge #(
  parameter int unsigned     DATA_W     = 8,
  parameter int unsigned     ADDR_W     = 5,
  parameter int unsigned     NREGS      = 16,
  parameter int unsigned     ACK_CYCLES = 1,
  parameter logic [NREGS-1:0] WRITE_MASK = '1
) (
  input  logic                    CLK50,
  input  logic                    rst_n,
  mcu_bus_if.slave                bus,
  input  logic [NREGS*DATA_W-1:0] reg_data_in,
  output logic [NREGS*DATA_W-1:0] reg_data_out,
  output logic [NREGS-1:0]        wr_stb,
  output logic [NREGS-1:0]        rd_stb
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, SETUP, ACK, HOLD} state_e;

  state_e                  state_q, state_d;
  logic                    sync1_q, mstr_s_q;
  logic [CNT_W-1:0]        ack_cnt_q, ack_cnt_d;
  logic [DATA_W-1:0]       data_out_q, data_out_d;
  logic                    data_oe_q, data_oe_d;
  logic                    fpga_ack_q, fpga_ack_d;
  logic                    addr_err_q, addr_err_d;
  logic [NREGS*DATA_W-1:0] regs_q, regs_d;
  logic [NREGS-1:0]        wr_stb_q, wr_stb_d;
  logic [NREGS-1:0]        rd_stb_q, rd_stb_d;
  logic                    in_range_c;
  logic [DATA_W-1:0]       rd_sel_c;

  // Two-flop synchroniser for the asynchronous request line
  always_ff @(posedge CLK50) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      mstr_s_q <= 1'b0;
    end else begin
      sync1_q  <= bus.mcu_mstr;
      mstr_s_q <= sync1_q;
    end
  end

  assign in_range_c = ({1'b0, bus.address} < (ADDR_W+1)'(NREGS));

  // Out-of-range reads return all ones
  always_comb begin
    rd_sel_c = '1;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (bus.address == ADDR_W'(i)) rd_sel_c = reg_data_in[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    ack_cnt_d  = ack_cnt_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    fpga_ack_d = fpga_ack_q;
    addr_err_d = addr_err_q;
    regs_d     = regs_q;
    wr_stb_d   = '0;
    rd_stb_d   = '0;
    case (state_q)
      IDLE: begin
        if (mstr_s_q) state_d = SETUP;
      end
      SETUP: begin
        if (!mstr_s_q) begin
          state_d    = IDLE;
          data_oe_d  = 1'b0;
          fpga_ack_d = 1'b0;
        end else begin
          state_d    = ACK;
          fpga_ack_d = 1'b1;
          ack_cnt_d  = CNT_W'(1);
          addr_err_d = !in_range_c;
          if (bus.write_enable) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
              if (bus.address == ADDR_W'(i) && WRITE_MASK[i]) begin
                regs_d[i*DATA_W +: DATA_W] = bus.data_in;
                wr_stb_d[i]                = 1'b1;
              end
            end
          end else begin
            data_oe_d  = 1'b1;
            data_out_d = rd_sel_c;
            for (int unsigned i = 0; i < NREGS; i++) begin
              if (bus.address == ADDR_W'(i)) rd_stb_d[i] = 1'b1;
            end
          end
        end
      end
      ACK: begin
        // A dropped request aborts; the committed access stays in place
        if (!mstr_s_q) begin
          state_d    = IDLE;
          fpga_ack_d = 1'b0;
          data_oe_d  = 1'b0;
        end else if (ack_cnt_q == CNT_W'(ACK_CYCLES)) begin
          state_d    = HOLD;
          fpga_ack_d = 1'b0;
        end else begin
          ack_cnt_d = ack_cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!mstr_s_q) begin
          state_d   = IDLE;
          data_oe_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK50) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ack_cnt_q  <= '0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      fpga_ack_q <= 1'b0;
      addr_err_q <= 1'b0;
      regs_q     <= '0;
      wr_stb_q   <= '0;
      rd_stb_q   <= '0;
    end else begin
      state_q    <= state_d;
      ack_cnt_q  <= ack_cnt_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      fpga_ack_q <= fpga_ack_d;
      addr_err_q <= addr_err_d;
      regs_q     <= regs_d;
      wr_stb_q   <= wr_stb_d;
      rd_stb_q   <= rd_stb_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.data_oe  = data_oe_q;
  assign bus.fpga_ack = fpga_ack_q;
  assign bus.addr_err = addr_err_q;
  assign reg_data_out = regs_q;
  assign wr_stb       = wr_stb_q;
  assign rd_stb       = rd_stb_q;

endmodule

// File: tb/tb_mcu_bus_bridge.sv
// Directed bench: DUT A (ACK_CYCLES=1, reg 0 read-only), DUT B (ACK_CYCLES=4).
module tb_mcu_bus_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cur_edge = 0;

  logic [127:0] reg_data_in_a, reg_data_in_b;
  logic [127:0] reg_data_out_a, reg_data_out_b;
  logic [15:0]  wr_stb_a, wr_stb_b, rd_stb_a, rd_stb_b;

  mcu_bus_if #(.DATA_W(8), .ADDR_W(5)) if_a ();
  mcu_bus_if #(.DATA_W(8), .ADDR_W(5)) if_b ();

  always #10 clk = ~clk;

  mcu_bus_bridge #(.DATA_W(8), .ADDR_W(5), .NREGS(16), .ACK_CYCLES(1),
                   .WRITE_MASK(16'hFFFE)) u_a (
    .CLK50(clk), .rst_n(rst_n), .bus(if_a),
    .reg_data_in(reg_data_in_a), .reg_data_out(reg_data_out_a),
    .wr_stb(wr_stb_a), .rd_stb(rd_stb_a));

  mcu_bus_bridge #(.DATA_W(8), .ADDR_W(5), .NREGS(16), .ACK_CYCLES(4),
                   .WRITE_MASK(16'hFFFF)) u_b (
    .CLK50(clk), .rst_n(rst_n), .bus(if_b),
    .reg_data_in(reg_data_in_b), .reg_data_out(reg_data_out_b),
    .wr_stb(wr_stb_b), .rd_stb(rd_stb_b));

  function automatic logic [7:0] reg_a(input int i);
    return reg_data_out_a[i*8 +: 8];
  endfunction

  function automatic logic [7:0] reg_b(input int i);
    return reg_data_out_b[i*8 +: 8];
  endfunction

  // Raise the request at a falling edge; returns just after E0
  task automatic start_txn(input bit on_b, input logic we, input logic [4:0] addr,
                           input logic [7:0] din);
    @(negedge clk);
    if (on_b) begin
      if_b.write_enable = we; if_b.address = addr; if_b.data_in = din; if_b.mcu_mstr = 1'b1;
    end else begin
      if_a.write_enable = we; if_a.address = addr; if_a.data_in = din; if_a.mcu_mstr = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cur_edge = 0;
  endtask

  // Advance to the falling edge after edge E<n>
  task automatic goto_edge(input int n);
    repeat (n - cur_edge) @(posedge clk);
    @(negedge clk);
    cur_edge = n;
  endtask

  task automatic end_txn(input bit on_b);
    if (on_b) if_b.mcu_mstr = 1'b0;
    else      if_a.mcu_mstr = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (if_a.fpga_ack !== 1'b0) begin errors++; $display("FAIL reset_ack_a: got %b want 0", if_a.fpga_ack); end
    checks++; if (if_a.data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe_a: got %b want 0", if_a.data_oe); end
    checks++; if (if_a.data_out !== 8'h00) begin errors++; $display("FAIL reset_dout_a: got %h want 00", if_a.data_out); end
    checks++; if (if_a.addr_err !== 1'b0) begin errors++; $display("FAIL reset_err_a: got %b want 0", if_a.addr_err); end
    checks++; if (reg_data_out_a !== 128'h0) begin errors++; $display("FAIL reset_regs_a: got %h want 0", reg_data_out_a); end
    checks++; if ({wr_stb_a, rd_stb_a} !== 32'h0) begin errors++; $display("FAIL reset_stb_a: got %h want 0", {wr_stb_a, rd_stb_a}); end
    checks++; if ({if_b.fpga_ack, if_b.data_oe, if_b.addr_err} !== 3'b000) begin errors++; $display("FAIL reset_flags_b: got %b want 000", {if_b.fpga_ack, if_b.data_oe, if_b.addr_err}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    start_txn(1'b0, 1'b1, 5'd3, 8'hA5);
    goto_edge(2);
    checks++; if (wr_stb_a !== 16'h0000) begin errors++; $display("FAIL wr_early_stb: got %h want 0000", wr_stb_a); end
    checks++; if (if_a.fpga_ack !== 1'b0) begin errors++; $display("FAIL wr_early_ack: got %b want 0", if_a.fpga_ack); end
    goto_edge(3);
    checks++; if (reg_a(3) !== 8'hA5) begin errors++; $display("FAIL wr_reg3: got %h want a5", reg_a(3)); end
    checks++; if (wr_stb_a !== 16'h0008) begin errors++; $display("FAIL wr_stb: got %h want 0008", wr_stb_a); end
    checks++; if (if_a.fpga_ack !== 1'b1) begin errors++; $display("FAIL wr_ack_hi: got %b want 1", if_a.fpga_ack); end
    checks++; if (if_a.data_oe !== 1'b0) begin errors++; $display("FAIL wr_oe: got %b want 0", if_a.data_oe); end
    goto_edge(4);
    checks++; if (wr_stb_a !== 16'h0000) begin errors++; $display("FAIL wr_stb_once: got %h want 0000", wr_stb_a); end
    checks++; if (if_a.fpga_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_len: got %b want 0", if_a.fpga_ack); end
    goto_edge(9);
    checks++; if ({if_a.fpga_ack, if_a.data_oe} !== 2'b00) begin errors++; $display("FAIL wr_hold: got %b want 00", {if_a.fpga_ack, if_a.data_oe}); end
    end_txn(1'b0);
  endtask

  task automatic test_read();
    start_txn(1'b0, 1'b0, 5'd7, 8'h00);
    goto_edge(2);
    checks++; if (if_a.data_oe !== 1'b0) begin errors++; $display("FAIL rd_early_oe: got %b want 0", if_a.data_oe); end
    goto_edge(3);
    checks++; if (if_a.data_out !== 8'h3C) begin errors++; $display("FAIL rd_data: got %h want 3c", if_a.data_out); end
    checks++; if (if_a.data_oe !== 1'b1) begin errors++; $display("FAIL rd_oe: got %b want 1", if_a.data_oe); end
    checks++; if (rd_stb_a !== 16'h0080) begin errors++; $display("FAIL rd_stb: got %h want 0080", rd_stb_a); end
    goto_edge(4);
    checks++; if (rd_stb_a !== 16'h0000) begin errors++; $display("FAIL rd_stb_once: got %h want 0000", rd_stb_a); end
    goto_edge(7);
    if_a.mcu_mstr = 1'b0;
    goto_edge(9);
    checks++; if (if_a.data_oe !== 1'b1) begin errors++; $display("FAIL rd_oe_hold: got %b want 1", if_a.data_oe); end
    goto_edge(10);
    checks++; if (if_a.data_oe !== 1'b0) begin errors++; $display("FAIL rd_oe_drop: got %b want 0", if_a.data_oe); end
    checks++; if (if_a.data_out !== 8'h3C) begin errors++; $display("FAIL rd_data_keep: got %h want 3c", if_a.data_out); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write_mask();
    start_txn(1'b0, 1'b1, 5'd0, 8'h55);
    goto_edge(3);
    checks++; if (reg_a(0) !== 8'h00) begin errors++; $display("FAIL mask_reg0: got %h want 00", reg_a(0)); end
    checks++; if (wr_stb_a !== 16'h0000) begin errors++; $display("FAIL mask_stb: got %h want 0000", wr_stb_a); end
    checks++; if (if_a.fpga_ack !== 1'b1) begin errors++; $display("FAIL mask_ack: got %b want 1", if_a.fpga_ack); end
    checks++; if (if_a.addr_err !== 1'b0) begin errors++; $display("FAIL mask_err: got %b want 0", if_a.addr_err); end
    goto_edge(5);
    end_txn(1'b0);
  endtask

  task automatic test_addr_err();
    start_txn(1'b0, 1'b1, 5'd31, 8'h77);
    goto_edge(3);
    checks++; if (wr_stb_a !== 16'h0000) begin errors++; $display("FAIL oor_wr_stb: got %h want 0000", wr_stb_a); end
    checks++; if (if_a.addr_err !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b want 1", if_a.addr_err); end
    checks++; if (reg_data_out_a !== 128'h0000_0000_0000_0000_0000_0000_A500_0000) begin errors++; $display("FAIL oor_wr_regs: got %h want a5 at reg3 only", reg_data_out_a); end
    goto_edge(5);
    end_txn(1'b0);
    start_txn(1'b0, 1'b0, 5'd20, 8'h00);
    goto_edge(3);
    checks++; if (if_a.data_out !== 8'hFF) begin errors++; $display("FAIL oor_rd_data: got %h want ff", if_a.data_out); end
    checks++; if (if_a.data_oe !== 1'b1) begin errors++; $display("FAIL oor_rd_oe: got %b want 1", if_a.data_oe); end
    checks++; if (rd_stb_a !== 16'h0000) begin errors++; $display("FAIL oor_rd_stb: got %h want 0000", rd_stb_a); end
    checks++; if (if_a.addr_err !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %b want 1", if_a.addr_err); end
    goto_edge(5);
    end_txn(1'b0);
    checks++; if (if_a.addr_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", if_a.addr_err); end
    start_txn(1'b0, 1'b1, 5'd1, 8'h11);
    goto_edge(2);
    checks++; if (if_a.addr_err !== 1'b1) begin errors++; $display("FAIL err_until_setup: got %b want 1", if_a.addr_err); end
    goto_edge(3);
    checks++; if (if_a.addr_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", if_a.addr_err); end
    checks++; if (reg_a(1) !== 8'h11) begin errors++; $display("FAIL err_wr_reg1: got %h want 11", reg_a(1)); end
    checks++; if (wr_stb_a !== 16'h0002) begin errors++; $display("FAIL err_wr_stb: got %h want 0002", wr_stb_a); end
    goto_edge(5);
    end_txn(1'b0);
  endtask

  task automatic test_abort();
    start_txn(1'b1, 1'b1, 5'd2, 8'h5A);
    goto_edge(3);
    checks++; if (if_b.fpga_ack !== 1'b1) begin errors++; $display("FAIL abort_ack_hi: got %b want 1", if_b.fpga_ack); end
    checks++; if (reg_b(2) !== 8'h5A) begin errors++; $display("FAIL abort_reg2: got %h want 5a", reg_b(2)); end
    if_b.mcu_mstr = 1'b0;
    goto_edge(5);
    checks++; if (if_b.fpga_ack !== 1'b1) begin errors++; $display("FAIL abort_ack_sync: got %b want 1", if_b.fpga_ack); end
    goto_edge(6);
    checks++; if (if_b.fpga_ack !== 1'b0) begin errors++; $display("FAIL abort_ack_drop: got %b want 0", if_b.fpga_ack); end
    checks++; if (reg_b(2) !== 8'h5A) begin errors++; $display("FAIL abort_kept: got %h want 5a", reg_b(2)); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    start_txn(1'b1, 1'b0, 5'd2, 8'h00);
    goto_edge(3);
    checks++; if (if_b.data_out !== 8'hC3) begin errors++; $display("FAIL b2b_data: got %h want c3", if_b.data_out); end
    checks++; if (rd_stb_b !== 16'h0004) begin errors++; $display("FAIL b2b_rd_stb: got %h want 0004", rd_stb_b); end
    goto_edge(6);
    checks++; if (if_b.fpga_ack !== 1'b1) begin errors++; $display("FAIL ack4_last: got %b want 1", if_b.fpga_ack); end
    goto_edge(7);
    checks++; if (if_b.fpga_ack !== 1'b0) begin errors++; $display("FAIL ack4_end: got %b want 0", if_b.fpga_ack); end
    checks++; if (if_b.data_oe !== 1'b1) begin errors++; $display("FAIL ack4_oe: got %b want 1", if_b.data_oe); end
    goto_edge(12);
    checks++; if ({if_b.fpga_ack, rd_stb_b} !== 17'h0) begin errors++; $display("FAIL no_retrigger: got %h want 0", {if_b.fpga_ack, rd_stb_b}); end
    end_txn(1'b1);
    checks++; if (if_b.data_oe !== 1'b0) begin errors++; $display("FAIL b2b_oe_idle: got %b want 0", if_b.data_oe); end
  endtask

  task automatic test_reset_mid();
    start_txn(1'b0, 1'b0, 5'd7, 8'h00);
    goto_edge(3);
    checks++; if ({if_a.fpga_ack, if_a.data_oe} !== 2'b11) begin errors++; $display("FAIL mid_pre: got %b want 11", {if_a.fpga_ack, if_a.data_oe}); end
    rst_n = 1'b0;
    goto_edge(4);
    checks++; if (if_a.fpga_ack !== 1'b0) begin errors++; $display("FAIL mid_ack: got %b want 0", if_a.fpga_ack); end
    checks++; if (if_a.data_oe !== 1'b0) begin errors++; $display("FAIL mid_oe: got %b want 0", if_a.data_oe); end
    checks++; if (reg_data_out_a !== 128'h0) begin errors++; $display("FAIL mid_regs: got %h want 0", reg_data_out_a); end
    checks++; if (if_a.data_out !== 8'h00) begin errors++; $display("FAIL mid_dout: got %h want 00", if_a.data_out); end
    rst_n = 1'b1;
    end_txn(1'b0);
  endtask

  initial begin
    if_a.mcu_mstr = 1'b0; if_a.write_enable = 1'b0; if_a.address = '0; if_a.data_in = '0;
    if_b.mcu_mstr = 1'b0; if_b.write_enable = 1'b0; if_b.address = '0; if_b.data_in = '0;
    reg_data_in_a = '0;
    reg_data_in_a[7*8 +: 8] = 8'h3C;
    reg_data_in_b = '0;
    reg_data_in_b[2*8 +: 8] = 8'hC3;
    test_reset();
    test_write();
    test_read();
    test_write_mask();
    test_addr_err();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcu_bus_bridge.md
Name: mcu_bus_bridge

Overview:
- Parametrised MCU-to-FPGA parallel register bridge; successor to the 16x8 MCU bus block.
- Generalised in data width, address width and register count.
- Adds: mcu_mstr synchroniser, transaction FSM, programmable ack length, per-register write mask, write/read strobes, out-of-range address detection, split tristate controls.
- Sits between the MCU pin pads (tristate at top level) and the FPGA register/peripheral logic.

Parameters:
- DATA_W, 8: data bus and register width.
- ADDR_W, 5: MCU address width.
- NREGS, 16: implemented registers, indices 0..NREGS-1; must satisfy 1 <= NREGS <= 2**ADDR_W.
- ACK_CYCLES, 1: CLK50 cycles fpga_ack stays high, range 1..15.
- WRITE_MASK, all ones (NREGS bits): bit i=1 makes register i writable; bit i=0 makes it read-only.

Ports:
- CLK50, in, 1: sole clock.
- rst_n, in, 1: synchronous, active-low reset.
- mcu_mstr, in, 1: MCU transaction request; asynchronous to CLK50, held high for the whole transaction.
- write_enable, in, 1: 1 = write, 0 = read; stable while mcu_mstr is high.
- address, in, ADDR_W: register index; stable while mcu_mstr is high.
- data_in, in, DATA_W: pad input data.
- data_out, out, DATA_W: read data driven to the pad.
- data_oe, out, 1: pad output enable.
- reg_data_in, in, NREGS*DATA_W: flattened register read sources; register i is at [i*DATA_W +: DATA_W].
- reg_data_out, out, NREGS*DATA_W: flattened written register values, same packing as reg_data_in.
- wr_stb, out, NREGS: one-cycle pulse on the bit of the written register.
- rd_stb, out, NREGS: one-cycle pulse on the bit of the read register.
- fpga_ack, out, 1: transaction acknowledge to the MCU.
- addr_err, out, 1: sticky out-of-range address flag.

Behaviour:
- Reset (rst_n=0 at an edge): all outputs 0; reg_data_out all 0; FSM in IDLE; synchroniser flops cleared.
- Synchroniser: mcu_mstr passes through 2 flops to give mstr_s. No other input is synchronised.
- Cycle numbering: E0 is the first edge that samples mcu_mstr=1.
- IDLE: on mstr_s=1 (at E2), go to SETUP.
- SETUP (one cycle, bus settle): at E3 sample write_enable, address and data_in, then go to ACK.
- Write, address < NREGS, WRITE_MASK bit = 1: after E3, the register slice takes data_in and wr_stb[address] is high for exactly one cycle.
- Write, address < NREGS, mask bit = 0: register unchanged, no wr_stb; fpga_ack proceeds normally and addr_err is not set.
- Read, address < NREGS: data_out takes reg_data_in[address] after E3; rd_stb[address] pulses for one cycle; data_oe rises after E3.
- Address >= NREGS:
  - Write: discarded, no strobe.
  - Read: data_out is all ones, no strobe, data_oe asserted.
  - Both: addr_err set after E3.
- addr_err stays set until the SETUP of the next transaction with an in-range address, where it clears.
- ACK: fpga_ack is high from after E3 through after E(2+ACK_CYCLES), then goes to HOLD with fpga_ack low.
- HOLD: wait for mstr_s=0, then go to IDLE. data_oe drops on the same edge that samples mstr_s=0.
- Abort: if mstr_s=0 is sampled in SETUP or ACK, go to IDLE at that edge and drop fpga_ack and data_oe. An access already committed in SETUP is kept.
- Back-to-back: a new transaction needs mstr_s to be seen low (IDLE) first. No re-trigger without a low phase.
- data_out holds its last value when data_oe=0.
- Reset mid-transaction: everything returns to reset values at that edge. The MCU must then drop mcu_mstr before starting a new request.

Test Plan:
- Reset, then write 0xA5 to addr 3 (mcu_mstr held 10 cycles) -> reg_data_out[3]=0xA5 and wr_stb=0x0008 for one cycle, both after E3; fpga_ack high for exactly 1 cycle after E3; data_oe stays 0.
- reg_data_in[7]=0x3C, read addr 7 -> data_out=0x3C and data_oe=1 from after E3 until mstr_s is sampled low; rd_stb=0x0080 for one cycle.
- WRITE_MASK=16'hFFFE, write 0x55 to addr 0 -> reg_data_out[0] stays 0x00, no wr_stb, fpga_ack still pulses, addr_err=0.
- Read addr 20 (NREGS=16) -> data_out=0xFF, addr_err=1; then write 0x11 to addr 1 -> addr_err clears at that SETUP and reg_data_out[1]=0x11.
- ACK_CYCLES=4 with mcu_mstr dropped 1 cycle after E3 -> fpga_ack is low within 3 edges of the drop (2 sync + 1 FSM) and the FSM returns to IDLE; the committed write is kept.
- Assert rst_n=0 during ACK -> next cycle fpga_ack=0, data_oe=0 and all reg_data_out=0.
